// File: rtl/midi_pkg.sv
// Shared FSM state encoding and MIDI protocol constants for the MIDI note transmitter.
package midi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        TX_STATUS,
        TX_NOTE,
        TX_VEL,
        COMMIT
    } midi_state_e;

    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [6:0] OFF_VEL  = 7'h40;

    // Stretch a 3-bit velocity over the 7-bit MIDI range; zero would mean Note Off, so it becomes 1.
    function automatic logic [6:0] vel7(input logic [2:0] v);
        return (v == 3'd0) ? 7'h01 : {v, v, v[2]};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with a valid/ready handshake; ready rises in the last stop-bit cycle
// so a waiting byte starts immediately after the stop bit.
module uart_byte_tx #(
    parameter int BIT_TICKS = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    logic          activeQ, activeD;
    logic [TW-1:0] tickQ, tickD;
    logic [3:0]    bitCntQ, bitCntD;
    logic [9:0]    shiftQ, shiftD;
    logic          bitDone;

    assign bitDone = (tickQ == TW'(BIT_TICKS - 1));
    assign ready_o = !activeQ || (bitDone && bitCntQ == 4'd9);
    assign tx_o    = shiftQ[0];

    // Shifting in ones behind the frame leaves the line idling high once the stop bit ends.
    always_comb begin
        activeD = activeQ;
        tickD   = tickQ;
        bitCntD = bitCntQ;
        shiftD  = shiftQ;
        if (activeQ) begin
            if (bitDone) begin
                tickD   = '0;
                shiftD  = {1'b1, shiftQ[9:1]};
                bitCntD = bitCntQ + 4'd1;
                if (bitCntQ == 4'd9) begin
                    activeD = 1'b0;
                end
            end else begin
                tickD = tickQ + TW'(1);
            end
        end
        if (valid_i && ready_o) begin
            activeD = 1'b1;
            tickD   = '0;
            bitCntD = '0;
            shiftD  = {1'b1, data_i, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            activeQ <= 1'b0;
            tickQ   <= '0;
            bitCntQ <= '0;
            shiftQ  <= '1;
        end else begin
            activeQ <= activeD;
            tickQ   <= tickD;
            bitCntQ <= bitCntD;
            shiftQ  <= shiftD;
        end
    end

endmodule

// File: rtl/midi_tx.sv
// Eight-voice MIDI Note On/Off transmitter: compares live voice inputs against the last
// transmitted state and sends one 3-byte message per change, lowest voice first.
module midi_tx
    import midi_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 31_250,
    parameter int MIDI_CHANNEL     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      on_in,
    input  logic [7:0][2:0] velocity_in,
    input  logic [7:0][6:0] note_in,
    output logic            data_out,
    output logic            busy,
    output logic            msg_sent
);
    localparam int         BIT_TICKS = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam logic [3:0] CHAN      = 4'(MIDI_CHANNEL);

    midi_state_e     stateQ, stateD;
    logic [7:0]      shadowOnQ, shadowOnD;
    logic [7:0][6:0] shadowNoteQ, shadowNoteD;
    logic [7:0][2:0] shadowVelQ, shadowVelD;
    logic [2:0]      selQ, selD;
    logic            msgOnQ, msgOnD;
    logic [6:0]      bufNoteQ, bufNoteD;
    logic [2:0]      bufVelQ, bufVelD;
    logic            velSentQ, velSentD;
    logic [7:0]      pending;
    logic            anyPending;
    logic [2:0]      lowestPending;
    logic            txValid, txReady;
    logic [7:0]      txData;

    // A held voice whose velocity alone changed is deliberately not pending.
    always_comb begin
        pending = '0;
        for (int i = 0; i < 8; i++) begin
            pending[i] = (on_in[i] != shadowOnQ[i]) ||
                         (on_in[i] && shadowOnQ[i] && (note_in[i] != shadowNoteQ[i]));
        end
        anyPending    = |pending;
        lowestPending = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                lowestPending = 3'(i);
            end
        end
    end

    always_comb begin
        stateD      = stateQ;
        shadowOnD   = shadowOnQ;
        shadowNoteD = shadowNoteQ;
        shadowVelD  = shadowVelQ;
        selD        = selQ;
        msgOnD      = msgOnQ;
        bufNoteD    = bufNoteQ;
        bufVelD     = bufVelQ;
        velSentD    = velSentQ;
        txValid     = 1'b0;
        txData      = '0;
        case (stateQ)
            IDLE: begin
                if (anyPending) begin
                    selD   = lowestPending;
                    stateD = SNAP;
                end
            end
            // A retrigger is sent as a Note Off; the Note On follows on the next scan.
            SNAP: begin
                if (!pending[selQ]) begin
                    stateD = IDLE;
                end else begin
                    msgOnD   = on_in[selQ] && !shadowOnQ[selQ];
                    bufNoteD = msgOnD ? note_in[selQ] : shadowNoteQ[selQ];
                    bufVelD  = msgOnD ? velocity_in[selQ] : shadowVelQ[selQ];
                    stateD   = TX_STATUS;
                end
            end
            TX_STATUS: begin
                txValid = 1'b1;
                txData  = {msgOnQ ? NOTE_ON : NOTE_OFF, CHAN};
                if (txReady) begin
                    stateD = TX_NOTE;
                end
            end
            TX_NOTE: begin
                txValid = 1'b1;
                txData  = {1'b0, bufNoteQ};
                if (txReady) begin
                    stateD = TX_VEL;
                end
            end
            TX_VEL: begin
                txValid = !velSentQ;
                txData  = {1'b0, msgOnQ ? vel7(bufVelQ) : OFF_VEL};
                if (txReady) begin
                    if (velSentQ) begin
                        velSentD = 1'b0;
                        stateD   = COMMIT;
                    end else begin
                        velSentD = 1'b1;
                    end
                end
            end
            COMMIT: begin
                shadowOnD[selQ]   = msgOnQ;
                shadowNoteD[selQ] = bufNoteQ;
                shadowVelD[selQ]  = bufVelQ;
                stateD            = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= IDLE;
            shadowOnQ   <= '0;
            shadowNoteQ <= '0;
            shadowVelQ  <= '0;
            selQ        <= '0;
            msgOnQ      <= 1'b0;
            bufNoteQ    <= '0;
            bufVelQ     <= '0;
            velSentQ    <= 1'b0;
        end else begin
            stateQ      <= stateD;
            shadowOnQ   <= shadowOnD;
            shadowNoteQ <= shadowNoteD;
            shadowVelQ  <= shadowVelD;
            selQ        <= selD;
            msgOnQ      <= msgOnD;
            bufNoteQ    <= bufNoteD;
            bufVelQ     <= bufVelD;
            velSentQ    <= velSentD;
        end
    end

    assign busy     = (stateQ != IDLE) && (stateQ != COMMIT);
    assign msg_sent = (stateQ == COMMIT);

    uart_byte_tx #(
        .BIT_TICKS(BIT_TICKS)
    ) u_uart (
        .clk    (clk),
        .rst    (rst),
        .valid_i(txValid),
        .data_i (txData),
        .ready_o(txReady),
        .tx_o   (data_out)
    );

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: a serial receiver decodes data_out and compares each byte against
// a queue of expected bytes pushed when each voice change is driven.
module tb_midi_tx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CHAN     = 3;
    localparam int BT       = 16;
    localparam int ST_ON    = 8'h90 | CHAN;
    localparam int ST_OFF   = 8'h80 | CHAN;
    localparam int MSG_CYC  = 30 * BT;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      on_in;
    logic [7:0][2:0] velocity_in;
    logic [7:0][6:0] note_in;
    logic            data_out;
    logic            busy;
    logic            msg_sent;

    int checksTotal  = 0;
    int checksPassed = 0;
    int cycleCount   = 0;
    int msgCount     = 0;
    int lastMsgCycle = 0;
    int expQ[$];

    midi_tx #(
        .INPUT_CLOCK_FREQ(CLK_FREQ),
        .BAUD_RATE       (BAUD),
        .MIDI_CHANNEL    (CHAN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .on_in      (on_in),
        .velocity_in(velocity_in),
        .note_in    (note_in),
        .data_out   (data_out),
        .busy       (busy),
        .msg_sent   (msg_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checksTotal++;
        if (observed == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int voice, input bit on, input int note, input int vel);
        on_in[voice]       = on;
        note_in[voice]     = 7'(note);
        velocity_in[voice] = 3'(vel);
    endtask

    task automatic pushMsg(input int st, input int note, input int vel);
        expQ.push_back(st);
        expQ.push_back(note);
        expQ.push_back(vel);
    endtask

    task automatic waitMsgs(input int target, input int budget);
        for (int i = 0; i < budget && msgCount < target; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("msg_count", msgCount, target);
        checkOutput("sb_empty", expQ.size(), 0);
        checkOutput("busy_after", int'(busy), 0);
    endtask

    task automatic waitLow(input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (data_out === 1'b0) begin
                cyc = cycleCount;
                break;
            end
        end
    endtask

    task automatic quietCheck(input int cycles, input int expectMsgs);
        int lowCount = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (data_out !== 1'b1) lowCount++;
        end
        checkOutput("quiet_line", lowCount, 0);
        checkOutput("quiet_msgs", msgCount, expectMsgs);
    endtask

    always @(negedge clk) begin
        if (!rst && msg_sent === 1'b1) begin
            msgCount++;
            lastMsgCycle = cycleCount;
        end
    end

    // Mid-bit sampling receiver; a reset abandons any frame in flight.
    bit         rxActive = 1'b0;
    int         rxTimer  = 0;
    logic [7:0] rxByte;
    always @(negedge clk) begin
        if (rst) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (data_out === 1'b0) begin
                rxActive = 1'b1;
                rxTimer  = 0;
            end
        end else begin
            rxTimer++;
            if (rxTimer == BT / 2) begin
                checkOutput("start_bit", int'(data_out), 0);
            end else if (rxTimer > BT / 2 && (rxTimer - BT / 2) % BT == 0) begin
                if ((rxTimer - BT / 2) / BT <= 8) begin
                    rxByte[(rxTimer - BT / 2) / BT - 1] = data_out;
                end else begin
                    checkOutput("stop_bit", int'(data_out), 1);
                    rxActive = 1'b0;
                    if (expQ.size() == 0) checkOutput("rx_unexpected", int'(rxByte), -1);
                    else checkOutput("rx_byte", int'(rxByte), expQ.pop_front());
                end
            end
        end
    end

    initial begin
        int driveCycle;
        int startCycle;
        int base;

        rst         = 1'b1;
        on_in       = '0;
        velocity_in = '0;
        note_in     = '0;
        repeat (5) @(negedge clk);
        checkOutput("reset_data_out", int'(data_out), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_msg_sent", int'(msg_sent), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        quietCheck(4 * BT, 0);

        // Note On; velocity changed mid-message must not alter the buffered byte.
        @(posedge clk); #2;
        driveCycle = cycleCount;
        pushMsg(ST_ON, 8'h3C, 8'h7F);
        applyStimulus(0, 1'b1, 60, 7);
        waitLow(20, startCycle);
        checkOutput("start_latency_ok", int'(startCycle >= 0 && startCycle - driveCycle <= 3), 1);
        checkOutput("busy_during", int'(busy), 1);
        @(posedge clk); #2;
        velocity_in[0] = 3'd0;
        waitMsgs(1, MSG_CYC + 50);
        checkOutput("msg_span", lastMsgCycle - startCycle, MSG_CYC);

        // Note Off reports the shadow note even though note_in moved.
        @(posedge clk); #2;
        pushMsg(ST_OFF, 8'h3C, 8'h40);
        applyStimulus(0, 1'b0, 99, 0);
        waitMsgs(2, MSG_CYC + 50);

        @(posedge clk); #2;
        pushMsg(ST_ON, 8'h40, 8'h5B);
        pushMsg(ST_ON, 8'h43, 8'h5B);
        applyStimulus(5, 1'b1, 67, 5);
        applyStimulus(2, 1'b1, 64, 5);
        waitMsgs(4, 2 * MSG_CYC + 50);

        @(posedge clk); #2;
        pushMsg(ST_ON, 8'h3E, 8'h36);
        applyStimulus(1, 1'b1, 62, 3);
        waitMsgs(5, MSG_CYC + 50);
        @(posedge clk); #2;
        pushMsg(ST_OFF, 8'h3E, 8'h40);
        pushMsg(ST_ON, 8'h41, 8'h36);
        applyStimulus(1, 1'b1, 65, 3);
        waitMsgs(7, 2 * MSG_CYC + 50);

        @(posedge clk); #2;
        pushMsg(ST_ON, 8'h0A, 8'h01);
        applyStimulus(3, 1'b1, 10, 0);
        waitMsgs(8, MSG_CYC + 50);
        @(posedge clk); #2;
        velocity_in[3] = 3'd6;
        quietCheck(10 * BT, 8);

        // Changes while busy: voice6 must be served later, voice7's toggle must vanish.
        @(posedge clk); #2;
        pushMsg(ST_ON, 8'h14, 8'h24);
        pushMsg(ST_ON, 8'h1E, 8'h12);
        applyStimulus(4, 1'b1, 20, 2);
        repeat (100) @(posedge clk);
        #2;
        applyStimulus(6, 1'b1, 30, 1);
        applyStimulus(7, 1'b1, 50, 4);
        repeat (20) @(posedge clk);
        #2;
        applyStimulus(7, 1'b0, 50, 4);
        waitMsgs(10, 2 * MSG_CYC + 50);
        quietCheck(10 * BT, 10);

        // Reset while the note byte is on the line.
        @(posedge clk); #2;
        expQ.push_back(ST_ON);
        applyStimulus(0, 1'b1, 60, 7);
        repeat (3 + 12 * BT + 4) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_low", int'(data_out), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_reset_data_out", int'(data_out), 1);
        checkOutput("mid_reset_busy", int'(busy), 0);
        checkOutput("sb_after_abort", expQ.size(), 0);
        @(posedge clk); #2;
        rst  = 1'b0;
        base = msgCount;
        pushMsg(ST_ON, 8'h3C, 8'h7F);
        pushMsg(ST_ON, 8'h41, 8'h36);
        pushMsg(ST_ON, 8'h40, 8'h5B);
        pushMsg(ST_ON, 8'h0A, 8'h6D);
        pushMsg(ST_ON, 8'h14, 8'h24);
        pushMsg(ST_ON, 8'h43, 8'h5B);
        pushMsg(ST_ON, 8'h1E, 8'h12);
        waitMsgs(base + 7, 7 * MSG_CYC + 100);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
